// File: rtl/magic_streamer_ctrl.sv
// Command-side controller for one streamer core: turns save/restore/clear commands into
// single-cycle core reset/init pulses and returns one status/beat-count response per command.
module magic_streamer_ctrl #(
   parameter int IDX_WIDTH     = 10,
   parameter int TIMEOUT_WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [TIMEOUT_WIDTH-1:0] cmd_timeout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [1:0]               rsp_status,
   output logic [IDX_WIDTH-1:0]     rsp_beats,
   output logic                     strm_store_rst,
   output logic                     strm_load_rst,
   output logic                     strm_store_init,
   output logic                     strm_load_init,
   input  logic                     strm_fin_store,
   input  logic [IDX_WIDTH-1:0]     strm_amt_store,
   input  logic                     mon_tvalid,
   input  logic                     mon_tready,
   input  logic                     mon_tlast,
   output logic                     busy,
   output logic [3:0]               dbg_state
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      SAVE_RST  = 4'd1,
      SAVE_INIT = 4'd2,
      SAVE_WAIT = 4'd3,
      LOAD_RST  = 4'd4,
      LOAD_INIT = 4'd5,
      LOAD_WAIT = 4'd6,
      CLR_ST    = 4'd7,
      CLR_LD    = 4'd8,
      RESP      = 4'd9
   } state_t;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_EMPTY   = 2'b10;
   localparam logic [1:0] ST_BADOP   = 2'b11;

   state_t                   state, state_d;
   logic [IDX_WIDTH-1:0]     beat_cnt, beat_cnt_d;
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt, tmo_cnt_d;
   logic                     tmo_en, tmo_en_d;
   logic                     tmo_hit;
   logic                     hs;
   logic                     rsp_load;
   logic [1:0]               status_d;
   logic [IDX_WIDTH-1:0]     beats_d;

   assign hs      = mon_tvalid & mon_tready;
   // Counter holds the remaining budget including the current cycle, so 1 means it expires now.
   assign tmo_hit = tmo_en && (tmo_cnt == TIMEOUT_WIDTH'(1));

   always_comb begin
      state_d    = state;
      beat_cnt_d = beat_cnt;
      tmo_cnt_d  = tmo_cnt;
      tmo_en_d   = tmo_en;
      rsp_load   = 1'b0;
      status_d   = ST_OK;
      beats_d    = '0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               tmo_cnt_d = cmd_timeout;
               tmo_en_d  = (cmd_timeout != '0);
               case (cmd_op)
                  2'b01: state_d = SAVE_RST;
                  2'b10: begin
                     if (strm_amt_store != '0) begin
                        state_d = LOAD_RST;
                     end else begin
                        state_d  = RESP;
                        rsp_load = 1'b1;
                        status_d = ST_EMPTY;
                     end
                  end
                  2'b11: state_d = CLR_ST;
                  default: begin
                     state_d  = RESP;
                     rsp_load = 1'b1;
                     status_d = ST_BADOP;
                  end
               endcase
            end
         end
         SAVE_RST:  state_d = SAVE_INIT;
         SAVE_INIT: state_d = SAVE_WAIT;
         SAVE_WAIT: begin
            if (tmo_en) tmo_cnt_d = tmo_cnt - TIMEOUT_WIDTH'(1);
            // Completion is checked first so it wins over a same-cycle timeout.
            if (strm_fin_store) begin
               state_d  = RESP;
               rsp_load = 1'b1;
               status_d = ST_OK;
               beats_d  = strm_amt_store;
            end else if (tmo_hit) begin
               state_d  = RESP;
               rsp_load = 1'b1;
               status_d = ST_TIMEOUT;
               beats_d  = strm_amt_store;
            end
         end
         LOAD_RST: state_d = LOAD_INIT;
         LOAD_INIT: begin
            beat_cnt_d = '0;
            state_d    = LOAD_WAIT;
         end
         LOAD_WAIT: begin
            if (tmo_en) tmo_cnt_d = tmo_cnt - TIMEOUT_WIDTH'(1);
            if (hs) beat_cnt_d = beat_cnt + IDX_WIDTH'(1);
            if (hs && mon_tlast) begin
               state_d  = RESP;
               rsp_load = 1'b1;
               status_d = ST_OK;
               beats_d  = beat_cnt_d;
            end else if (tmo_hit) begin
               state_d  = RESP;
               rsp_load = 1'b1;
               status_d = ST_TIMEOUT;
               beats_d  = beat_cnt_d;
            end
         end
         CLR_ST: state_d = CLR_LD;
         CLR_LD: begin
            state_d  = RESP;
            rsp_load = 1'b1;
            status_d = ST_OK;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         tmo_en          <= 1'b0;
         rsp_status      <= '0;
         rsp_beats       <= '0;
         strm_store_rst  <= 1'b0;
         strm_load_rst   <= 1'b0;
         strm_store_init <= 1'b0;
         strm_load_init  <= 1'b0;
      end else begin
         state           <= state_d;
         tmo_en          <= tmo_en_d;
         // Pulses are decoded from the next state so each one lines up with its state cycle.
         strm_store_rst  <= (state_d == SAVE_RST) || (state_d == CLR_ST);
         strm_load_rst   <= (state_d == LOAD_RST) || (state_d == CLR_LD);
         strm_store_init <= (state_d == SAVE_INIT);
         strm_load_init  <= (state_d == LOAD_INIT);
         if (rsp_load) begin
            rsp_status <= status_d;
            rsp_beats  <= beats_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      beat_cnt <= beat_cnt_d;
      tmo_cnt  <= tmo_cnt_d;
   end

   // Gated by reset so no command is advertised while the block is held in reset.
   assign cmd_ready = reset && (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_magic_streamer_ctrl.sv
// Directed bench for magic_streamer_ctrl: save, restore, empty, timeout, back-pressure,
// bad op, completion-vs-timeout priority and mid-operation reset.
module tb_magic_streamer_ctrl;

   localparam int IW = 10;
   localparam int TW = 24;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [TW-1:0] cmd_timeout = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [1:0]    rsp_status;
   logic [IW-1:0] rsp_beats;
   logic          strm_store_rst, strm_load_rst, strm_store_init, strm_load_init;
   logic          strm_fin_store = 1'b0;
   logic [IW-1:0] strm_amt_store = '0;
   logic          mon_tvalid = 1'b0;
   logic          mon_tready = 1'b0;
   logic          mon_tlast = 1'b0;
   logic          busy;
   logic [3:0]    dbg_state;
   logic [3:0]    pulses;

   int tests = 0;
   int fails = 0;

   magic_streamer_ctrl #(.IDX_WIDTH(IW), .TIMEOUT_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_timeout(cmd_timeout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_beats(rsp_beats),
      .strm_store_rst(strm_store_rst), .strm_load_rst(strm_load_rst),
      .strm_store_init(strm_store_init), .strm_load_init(strm_load_init),
      .strm_fin_store(strm_fin_store), .strm_amt_store(strm_amt_store),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   assign pulses = {strm_store_rst, strm_load_rst, strm_store_init, strm_load_init};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input int st, input int beats);
      chk({tag, "_valid"}, 32'(rsp_valid), 1);
      chk({tag, "_status"}, 32'(rsp_status), st);
      chk({tag, "_beats"}, 32'(rsp_beats), beats);
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("drain_idle", 32'(dbg_state), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      // Reset state
      repeat (2) tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_pulses", 32'(pulses), 0);
      reset = 1'b1;
      tick();
      chk("post_rst_ready", 32'(cmd_ready), 1);
      chk("post_rst_state", 32'(dbg_state), 0);

      // SAVE with a 5-beat store burst
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_timeout = '0;
      tick();
      cmd_valid = 1'b0;
      chk("save_rst_pulse", 32'(pulses), 4'b1000);
      chk("save_rst_state", 32'(dbg_state), 1);
      chk("save_busy_ready", 32'({busy, cmd_ready}), 2'b10);
      tick();
      chk("save_init_pulse", 32'(pulses), 4'b0010);
      tick();
      chk("save_wait_state", 32'(dbg_state), 3);
      chk("save_wait_pulse", 32'(pulses), 0);
      for (int i = 1; i <= 5; i++) begin
         strm_amt_store = IW'(i);
         tick();
         chk("save_still_wait", 32'(dbg_state), 3);
      end
      strm_fin_store = 1'b1;
      tick();
      strm_fin_store = 1'b0;
      chk_rsp("save", 0, 5);
      drain();

      // RESTORE of the 5 stored beats
      cmd_valid = 1'b1; cmd_op = 2'b10;
      tick();
      cmd_valid = 1'b0;
      chk("rest_rst_pulse", 32'(pulses), 4'b0100);
      tick();
      chk("rest_init_pulse", 32'(pulses), 4'b0001);
      tick();
      chk("rest_wait_state", 32'(dbg_state), 6);
      mon_tready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         mon_tvalid = 1'b1;
         mon_tlast  = (i == 5);
         tick();
         if (i < 5) chk("rest_still_wait", 32'(dbg_state), 6);
      end
      mon_tvalid = 1'b0; mon_tlast = 1'b0;
      chk_rsp("rest", 0, 5);
      drain();

      // RESTORE with nothing stored
      strm_amt_store = '0;
      cmd_valid = 1'b1; cmd_op = 2'b10;
      tick();
      cmd_valid = 1'b0;
      chk_rsp("empty", 2, 0);
      chk("empty_pulses", 32'(pulses), 0);
      drain();

      // SAVE timeout after 10 wait cycles
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_timeout = TW'(10);
      tick();
      cmd_valid = 1'b0;
      repeat (11) tick();
      chk("tmo_still_wait", 32'(dbg_state), 3);
      chk("tmo_no_rsp", 32'(rsp_valid), 0);
      tick();
      chk_rsp("tmo", 1, 0);
      drain();

      // RESTORE 3 beats with a stall beat, then response back-pressure
      strm_amt_store = IW'(3);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_timeout = '0;
      tick();
      cmd_valid = 1'b0;
      repeat (2) tick();
      mon_tvalid = 1'b1; mon_tready = 1'b1;
      tick();
      mon_tready = 1'b0;
      tick();
      mon_tready = 1'b1;
      tick();
      mon_tlast = 1'b1;
      tick();
      mon_tvalid = 1'b0; mon_tlast = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'b00;
      for (int i = 0; i < 7; i++) begin
         chk_rsp("bp", 0, 3);
         chk("bp_cmd_ready", 32'(cmd_ready), 0);
         tick();
      end
      drain();
      chk("bp_ready_after", 32'(cmd_ready), 1);

      // NOP held on cmd_valid is accepted once idle
      tick();
      cmd_valid = 1'b0;
      chk_rsp("badop", 3, 0);
      drain();

      // Completion and timeout in the same cycle
      strm_amt_store = IW'(7);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_timeout = TW'(1);
      tick();
      cmd_valid = 1'b0;
      tick();
      strm_fin_store = 1'b1;
      tick();
      tick();
      strm_fin_store = 1'b0;
      chk_rsp("tie", 0, 7);
      drain();

      // Reset in LOAD_WAIT, then CLEAR
      strm_amt_store = IW'(3);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_timeout = '0;
      tick();
      cmd_valid = 1'b0;
      repeat (2) tick();
      chk("lw_state", 32'(dbg_state), 6);
      reset = 1'b0;
      #1;
      chk("mid_rst_outs", 32'({cmd_ready, busy, rsp_valid, pulses, dbg_state}), 0);
      chk("mid_rst_rsp", 32'({rsp_status, rsp_beats}), 0);
      tick();
      reset = 1'b1;
      tick();
      chk("post_mid_pulses", 32'(pulses), 0);
      chk("post_mid_ready", 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_op = 2'b11;
      tick();
      cmd_valid = 1'b0;
      chk("clr_st_pulse", 32'(pulses), 4'b1000);
      tick();
      chk("clr_ld_pulse", 32'(pulses), 4'b0100);
      tick();
      chk_rsp("clr", 0, 0);
      chk("clr_resp_pulses", 32'(pulses), 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
